vga_pwm_scope: RTL

Parametrised VGA timing generator and PWM waveform renderer. It drives the board's 12-bit VGA connector and draws NUM_CH independent PWM duty-cycle traces, one per horizontal lane, each in its own colour. Duty values are sampled once per frame so the picture never tears. It replaces the fixed 640x480, single-trace display path and sits between the PWM/duty controller and the VGA pins.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_pwm_scope_if.sv | 32 +++
 rtl/vga_timing_gen.sv | 85 ++++++++
 rtl/vga_pwm_scope.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared VGA constants (640x480@60 defaults), rgb444 type, helpers
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int c_def_h_active = 640;
    localparam int c_def_h_fp     = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_bp     = 48;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_fp     = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_bp     = 33;

    typedef logic [11:0] rgb444_t;

    // Duty inputs are 7 bits wide, so anything above 100 must be saturated.
    function automatic logic [6:0] clamp_pct(input logic [6:0] pct);
        return (pct > 7'd100) ? 7'd100 : pct;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pwm_scope_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_pwm_scope_if
// Brief    : Duty/colour inputs and VGA pin outputs of the PWM scope
// Revision : 1.0
// ============================================================================
interface vga_pwm_scope_if #(
    parameter int NUM_CH = 2
);
    logic [7*NUM_CH-1:0]  duty;
    logic [12*NUM_CH-1:0] ch_color;
    logic [3:0]           red;
    logic [3:0]           green;
    logic [3:0]           blue;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic                 frame_start;
    logic [15:0]          h_count;
    logic [15:0]          v_count;

    modport master (
        output duty, ch_color,
        input  red, green, blue, hsync, vsync, de, frame_start, h_count, v_count
    );

    modport slave (
        input  duty, ch_color,
        output red, green, blue, hsync, vsync, de, frame_start, h_count, v_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Pixel/line counters with registered sync, de and frame pulse
// Revision : 1.0
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_def_h_active,
    parameter int H_FP     = c_def_h_fp,
    parameter int H_SYNC   = c_def_h_sync,
    parameter int H_BP     = c_def_h_bp,
    parameter int V_ACTIVE = c_def_v_active,
    parameter int V_FP     = c_def_v_fp,
    parameter int V_SYNC   = c_def_v_sync,
    parameter int V_BP     = c_def_v_bp,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        mhz_clk,
    input  logic        rst_n,
    output logic [15:0] o_h_count,
    output logic [15:0] o_v_count,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_frame_start
);

    localparam logic [15:0] c_h_last     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] c_v_last     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] c_h_active   = 16'(H_ACTIVE);
    localparam logic [15:0] c_v_active   = 16'(V_ACTIVE);
    localparam logic [15:0] c_hs_start   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_hs_end     = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] c_vs_start   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] c_vs_end     = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] r_h;
    logic [15:0] r_v;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic        w_hs_act;
    logic        w_vs_act;
    logic        w_vis;

    always_ff @(posedge mhz_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? 16'd0 : r_v + 16'd1;
        end else begin
            r_h <= r_h + 16'd1;
        end
    end

    assign w_hs_act = (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_vs_act = (r_v >= c_vs_start) && (r_v < c_vs_end);
    assign w_vis    = (r_h < c_h_active) && (r_v < c_v_active);

    // Registered one cycle behind the counters so they line up with the RGB register.
    always_ff @(posedge mhz_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b0;
        end else begin
            r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_de    <= w_vis;
        end
    end

    assign o_h_count     = r_h;
    assign o_v_count     = r_v;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_frame_start = (r_h == c_h_last) && (r_v == c_v_last);

endmodule
`default_nettype wire

// File: rtl/vga_pwm_scope.sv
`default_nettype none
// ============================================================================
// Module   : vga_pwm_scope
// Brief    : VGA renderer drawing one PWM duty trace per horizontal lane
// Revision : 1.0
// ============================================================================
module vga_pwm_scope
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = c_def_h_active,
    parameter int H_FP        = c_def_h_fp,
    parameter int H_SYNC      = c_def_h_sync,
    parameter int H_BP        = c_def_h_bp,
    parameter int V_ACTIVE    = c_def_v_active,
    parameter int V_FP        = c_def_v_fp,
    parameter int V_SYNC      = c_def_v_sync,
    parameter int V_BP        = c_def_v_bp,
    parameter bit SYNC_POL    = 1'b0,
    parameter int NUM_CH      = 2,
    parameter int PX_PER_PCT  = 6,
    parameter int LINE_W      = 4,
    parameter int LANE_MARGIN = 40
) (
    input  logic           mhz_clk,
    input  logic           rst_n,
    vga_pwm_scope_if.slave vga
);

    localparam int          c_lh       = V_ACTIVE / NUM_CH;
    localparam logic [15:0] c_h_active = 16'(H_ACTIVE);
    localparam logic [15:0] c_v_active = 16'(V_ACTIVE);
    localparam logic [15:0] c_x0       = 16'((H_ACTIVE - 100 * PX_PER_PCT) / 2);
    localparam logic [15:0] c_xe       = c_x0 + 16'(100 * PX_PER_PCT);
    localparam logic [15:0] c_lw       = 16'(LINE_W);
    localparam logic [7:0]  c_px       = 8'(PX_PER_PCT);

    logic [15:0]       w_h;
    logic [15:0]       w_v;
    logic              w_frame_start;
    logic              w_vis;
    logic [NUM_CH-1:0] w_lit;
    rgb444_t           w_rgb;
    rgb444_t           r_rgb;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .mhz_clk       (mhz_clk),
        .rst_n         (rst_n),
        .o_h_count     (w_h),
        .o_v_count     (w_v),
        .o_hsync       (vga.hsync),
        .o_vsync       (vga.vsync),
        .o_de          (vga.de),
        .o_frame_start (w_frame_start)
    );

    assign w_vis = (w_h < c_h_active) && (w_v < c_v_active);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [15:0] c_hi_top = 16'(k * c_lh + LANE_MARGIN);
        localparam logic [15:0] c_lo_top = 16'((k + 1) * c_lh - LANE_MARGIN - LINE_W);

        logic [6:0]  r_shadow;
        logic [14:0] w_prod;
        logic [15:0] w_xd;
        logic        w_hi_rail;
        logic        w_lo_rail;
        logic        w_span;
        logic        w_partial;
        logic        w_bar;

        // Frame-synchronous copy of duty keeps each picture tear-free.
        always_ff @(posedge mhz_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= '0;
            end else if (w_frame_start) begin
                r_shadow <= clamp_pct(vga.duty[7*k +: 7]);
            end
        end

        assign w_prod    = {8'd0, r_shadow} * {7'd0, c_px};
        assign w_xd      = c_x0 + {1'b0, w_prod};
        assign w_hi_rail = (w_v >= c_hi_top) && (w_v < c_hi_top + c_lw);
        assign w_lo_rail = (w_v >= c_lo_top) && (w_v < c_lo_top + c_lw);
        assign w_span    = (w_v >= c_hi_top) && (w_v < c_lo_top + c_lw);
        assign w_partial = (r_shadow != 7'd0) && (r_shadow < 7'd100);
        assign w_bar     = w_partial && w_span &&
                           (((w_h >= c_x0) && (w_h < c_x0 + c_lw)) ||
                            ((w_h >= w_xd) && (w_h < w_xd + c_lw)) ||
                            ((w_h >= c_xe) && (w_h < c_xe + c_lw)));
        assign w_lit[k]  = w_vis &&
                           ((w_hi_rail && (w_h >= c_x0) && (w_h < w_xd)) ||
                            (w_lo_rail && (w_h >= w_xd) && (w_h < c_xe)) ||
                            w_bar);
    end

    // Descending scan so the lowest lit channel index takes the pixel.
    always_comb begin
        w_rgb = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_lit[k]) begin
                w_rgb = vga.ch_color[12*k +: 12];
            end
        end
    end

    always_ff @(posedge mhz_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign vga.red         = r_rgb[11:8];
    assign vga.green       = r_rgb[7:4];
    assign vga.blue        = r_rgb[3:0];
    assign vga.frame_start = w_frame_start;
    assign vga.h_count     = w_h;
    assign vga.v_count     = w_v;

endmodule
`default_nettype wire
